fm_wm_mem_sequencer: RTL and testbench
======================================

// Module: fm_wm_mem_sequencer
// PURPOSE
//  Sequences the FM*WM product memory of the GCN datapath. In the FILL phase it accepts a
//  valid/ready stream of dot-product results and generates the row/column write addresses
//  and write enable, in row-major order. In the SERVE phase it grants row-read requests
//  from the aggregation stage. The memory itself is external; this block owns only
//  addressing and handshakes.
// PARAMETERS
//  FEATURE_ROWS    6                        rows of FM*WM result (feature matrix rows)
//  WEIGHT_COLS     3                        cols of FM*WM result (weight matrix cols)
//  DOT_PROD_WIDTH  16                       width of one dot-product element
//  FEATURE_WIDTH   $clog2(FEATURE_ROWS)     row address width
//  WEIGHT_WIDTH    $clog2(WEIGHT_COLS)      column address width
// PORTS
//  clk            in   1               clock
//  rst            in   1               asynchronous, active-high reset
//  start          in   1               begin FILL phase (honoured only in IDLE)
//  clear          in   1               abandon the matrix; return to IDLE
//  dp_valid       in   1               dot-product element valid
//  dp_data        in   DOT_PROD_WIDTH  dot-product element
//  dp_ready       out  1               block accepts dp_data this cycle
//  mem_wr_en      out  1               memory write enable
//  mem_write_row  out  FEATURE_WIDTH   memory write row
//  mem_write_col  out  WEIGHT_WIDTH    memory write column
//  mem_wr_data    out  DOT_PROD_WIDTH  memory write data
//  rd_req         in   1               aggregator row-read request
//  rd_row         in   3               requested row
//  rd_valid       out  1               memory row output is valid for the granted row
//  rd_err         out  1               request rejected (row >= FEATURE_ROWS)
//  mem_read_row   out  3               memory read row select
//  fill_done      out  1               all FEATURE_ROWS*WEIGHT_COLS elements written
//  busy           out  1               state != IDLE
// BEHAVIOUR
//  - Reset: state = IDLE; all outputs 0; row/col counters 0.
//  - States:
//    - IDLE -> FILL on start.
//    - FILL -> SERVE after the last element write.
//    - SERVE -> IDLE on clear.
//    - FILL -> IDLE on clear.
//  - clear has priority over every other event in the same cycle.
//  - FILL:
//    - dp_ready = 1 (combinational, state-decoded).
//    - On a dp_valid && dp_ready cycle: mem_wr_en = dp_valid && dp_ready, combinational,
//      with write row/col = current counters and mem_wr_data = dp_data.
//    - After the write, col increments. At col == WEIGHT_COLS-1, col wraps to 0 and row
//      increments.
//    - The write at (FEATURE_ROWS-1, WEIGHT_COLS-1) moves the state to SERVE and resets
//      the counters to 0.
//    - dp_valid low: no write; counters hold.
//  - SERVE:
//    - fill_done = 1; dp_ready = 0. dp_valid is ignored.
//    - rd_req with rd_row < FEATURE_ROWS: mem_read_row <= rd_row (registered) and
//      rd_valid pulses 1 on the next cycle.
//    - rd_req with rd_row >= FEATURE_ROWS: rd_err pulses 1 next cycle; mem_read_row holds.
//    - Back-to-back requests are accepted every cycle (1-cycle latency, fully pipelined).
//  - start outside IDLE is ignored.
//  - rd_req outside SERVE is ignored (no rd_valid, no rd_err).
//  - On clear, fill_done drops the next cycle; the memory contents are not cleared.
//  - Asynchronous reset mid-FILL aborts the fill. Partial writes already done remain in
//    memory; the memory has its own reset.
// CONFIGURATION
//  - FM_WM_STALL_CNT_EN defined:
//    - Adds output stall_cnt [15:0], counting FILL cycles with dp_valid == 0.
//    - stall_cnt clears on start, saturates at 16'hFFFF, and resets to 0.
//  - FM_WM_STALL_CNT_EN undefined: the port and counter are absent; behaviour is
//    otherwise identical.
// STRUCTURE
//  - Package fm_wm_pkg:
//    - typedef enum logic [1:0] {IDLE, FILL, SERVE} fm_wm_state_t
//    - localparam READ_ROW_WIDTH = 3
//  - Sub-module fm_wm_addr_counter (parameterised row/col wrap counter with inc, clr and
//    last outputs), instantiated once for the write address.
// TESTING
//  1. Reset mid-FILL (after 5 writes):
//     -> busy = 0, dp_ready = 0, all outputs 0.
//     -> A following start refills from (0,0).
//  2. start, then 18 consecutive dp_valid with data 1..18:
//     -> writes (0,0)=1, (0,1)=2, (0,2)=3, (1,0)=4 ... (5,2)=18.
//     -> fill_done = 1 the cycle after the 18th write; dp_ready = 0 afterwards.
//  3. FILL with dp_valid toggling every other cycle:
//     -> exactly 18 writes, correct order, no write on idle cycles.
//     -> With FM_WM_STALL_CNT_EN: stall_cnt == 17 at the end (one idle cycle between
//        each pair of the 18 valid cycles).
//  4. SERVE, rd_req rows 0,5,2 on back-to-back cycles:
//     -> mem_read_row = 0,5,2 and rd_valid high for 3 cycles, each 1 cycle after its
//        request.
//  5. SERVE, rd_req rd_row = 6 and rd_row = 7:
//     -> rd_err pulses, rd_valid stays 0, mem_read_row unchanged.
//  6. clear together with dp_valid during FILL:
//     -> no write that cycle; state IDLE.
//     -> start during FILL is ignored; rd_req in IDLE produces no response.

Source files
------------

// File: rtl/fm_wm_pkg.sv
// Shared types for the FM*WM product-memory sequencer.
package fm_wm_pkg;

    typedef enum logic [1:0] {IDLE, FILL, SERVE} fm_wm_state_t;

    localparam int unsigned READ_ROW_WIDTH = 3;

endpackage

// File: rtl/fm_wm_addr_counter.sv
// Row-major row/column wrap counter; last flags the final (ROWS-1, COLS-1) position.
module fm_wm_addr_counter #(
    parameter int unsigned ROWS      = 6,
    parameter int unsigned COLS      = 3,
    parameter int unsigned ROW_WIDTH = 3,
    parameter int unsigned COL_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [ROW_WIDTH-1:0] row,
    output logic [COL_WIDTH-1:0] col,
    output logic                 last
);

    localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(ROWS - 1);
    localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(COLS - 1);

    logic [ROW_WIDTH-1:0] row_q, row_d;
    logic [COL_WIDTH-1:0] col_q, col_d;
    logic                 col_last;

    assign col_last = (col_q == COL_LAST);
    assign last     = col_last && (row_q == ROW_LAST);
    assign row      = row_q;
    assign col      = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_last) begin
                col_d = '0;
                row_d = last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/fm_wm_mem_sequencer.sv
// FM*WM product memory sequencer: row-major FILL addressing, then SERVE row-read grants.
// Optional FM_WM_STALL_CNT_EN adds stall_cnt, counting FILL cycles without dp_valid.
module fm_wm_mem_sequencer
    import fm_wm_pkg::*;
#(
    parameter int unsigned FEATURE_ROWS   = 6,
    parameter int unsigned WEIGHT_COLS    = 3,
    parameter int unsigned DOT_PROD_WIDTH = 16,
    parameter int unsigned FEATURE_WIDTH  = $clog2(FEATURE_ROWS),
    parameter int unsigned WEIGHT_WIDTH   = $clog2(WEIGHT_COLS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      clear,
    input  logic                      dp_valid,
    input  logic [DOT_PROD_WIDTH-1:0] dp_data,
    output logic                      dp_ready,
    output logic                      mem_wr_en,
    output logic [FEATURE_WIDTH-1:0]  mem_write_row,
    output logic [WEIGHT_WIDTH-1:0]   mem_write_col,
    output logic [DOT_PROD_WIDTH-1:0] mem_wr_data,
    input  logic                      rd_req,
    input  logic [READ_ROW_WIDTH-1:0] rd_row,
    output logic                      rd_valid,
    output logic                      rd_err,
    output logic [READ_ROW_WIDTH-1:0] mem_read_row,
    output logic                      fill_done,
`ifdef FM_WM_STALL_CNT_EN
    output logic                      busy,
    output logic [15:0]               stall_cnt
`else
    output logic                      busy
`endif
);

    fm_wm_state_t state_q, state_d;
    logic         wr_fire;
    logic         wr_last;
    logic         rd_fire;
    logic         row_ok;

    // clear outranks a pending write in the same cycle
    assign wr_fire     = (state_q == FILL) && dp_valid && !clear;
    assign mem_wr_en   = wr_fire;
    assign mem_wr_data = wr_fire ? dp_data : '0;

    fm_wm_addr_counter #(
        .ROWS      (FEATURE_ROWS),
        .COLS      (WEIGHT_COLS),
        .ROW_WIDTH (FEATURE_WIDTH),
        .COL_WIDTH (WEIGHT_WIDTH)
    ) u_wr_addr (
        .clk  (clk),
        .rst  (rst),
        .inc  (wr_fire),
        .clr  (clear),
        .row  (mem_write_row),
        .col  (mem_write_col),
        .last (wr_last)
    );

    always_comb begin
        state_d   = state_q;
        dp_ready  = 1'b0;
        fill_done = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start && !clear) state_d = FILL;
            end
            FILL: begin
                dp_ready = 1'b1;
                if (clear)                  state_d = IDLE;
                else if (wr_fire && wr_last) state_d = SERVE;
            end
            SERVE: begin
                fill_done = 1'b1;
                if (clear) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign rd_fire = (state_q == SERVE) && rd_req && !clear;
    assign row_ok  = (32'(rd_row) < FEATURE_ROWS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid     <= 1'b0;
            rd_err       <= 1'b0;
            mem_read_row <= '0;
        end else begin
            rd_valid <= rd_fire && row_ok;
            rd_err   <= rd_fire && !row_ok;
            if (rd_fire && row_ok) mem_read_row <= rd_row;
        end
    end

`ifdef FM_WM_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state_q == IDLE && start && !clear) begin
            stall_cnt <= '0;
        end else if (state_q == FILL && !dp_valid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fm_wm_mem_sequencer.sv
// Randomised bench for fm_wm_mem_sequencer against a write-index/phase model.
module tb_fm_wm_mem_sequencer;

    localparam int ROWS = 6;
    localparam int COLS = 3;
    localparam int N    = ROWS * COLS;

    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0, clear = 1'b0, dp_valid = 1'b0, rd_req = 1'b0;
    logic [15:0] dp_data = '0;
    logic [2:0]  rd_row = '0;
    logic        dp_ready, mem_wr_en, rd_valid, rd_err, fill_done, busy;
    logic [2:0]  mem_write_row, mem_read_row;
    logic [1:0]  mem_write_col;
    logic [15:0] mem_wr_data;
`ifdef FM_WM_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    fm_wm_mem_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .clear         (clear),
        .dp_valid      (dp_valid),
        .dp_data       (dp_data),
        .dp_ready      (dp_ready),
        .mem_wr_en     (mem_wr_en),
        .mem_write_row (mem_write_row),
        .mem_write_col (mem_write_col),
        .mem_wr_data   (mem_wr_data),
        .rd_req        (rd_req),
        .rd_row        (rd_row),
        .rd_valid      (rd_valid),
        .rd_err        (rd_err),
        .mem_read_row  (mem_read_row),
        .fill_done     (fill_done),
`ifdef FM_WM_STALL_CNT_EN
        .busy          (busy),
        .stall_cnt     (stall_cnt)
`else
        .busy          (busy)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: phase 0 idle, 1 fill, 2 serve; m_k = writes done in this fill
    int          m_state = 0;
    int          m_k = 0;
    int          m_stall = 0;
    logic        m_rv = 1'b0, m_re = 1'b0;
    logic [2:0]  m_rrow = '0;
    logic [15:0] shadow [ROWS][COLS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0;
            m_k     <= 0;
            m_stall <= 0;
            m_rv    <= 1'b0;
            m_re    <= 1'b0;
            m_rrow  <= '0;
        end else begin
            m_rv <= (m_state == 2) && !clear && rd_req && (int'(rd_row) < ROWS);
            m_re <= (m_state == 2) && !clear && rd_req && (int'(rd_row) >= ROWS);
            if (m_state == 2 && !clear && rd_req && int'(rd_row) < ROWS) m_rrow <= rd_row;
            if (m_state == 1 && !dp_valid && m_stall < 65535) m_stall <= m_stall + 1;
            if (clear) begin
                m_state <= 0;
                m_k     <= 0;
            end else if (m_state == 0 && start) begin
                m_state <= 1;
                m_k     <= 0;
                m_stall <= 0;
            end else if (m_state == 1 && dp_valid) begin
                if (m_k + 1 == N) begin
                    m_state <= 2;
                    m_k     <= 0;
                end else begin
                    m_k <= m_k + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_wr;
        #2;
        exp_wr = (m_state == 1) && dp_valid && !clear;
        chk("dp_ready", 32'(dp_ready), 32'(m_state == 1));
        chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_wr));
        chk("mem_write_row", 32'(mem_write_row), 32'(m_k / COLS));
        chk("mem_write_col", 32'(mem_write_col), 32'(m_k % COLS));
        chk("mem_wr_data", 32'(mem_wr_data), exp_wr ? 32'(dp_data) : 32'd0);
        chk("fill_done", 32'(fill_done), 32'(m_state == 2));
        chk("busy", 32'(busy), 32'(m_state != 0));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("rd_err", 32'(rd_err), 32'(m_re));
        chk("mem_read_row", 32'(mem_read_row), 32'(m_rrow));
`ifdef FM_WM_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
        if (mem_wr_en && int'(mem_write_row) < ROWS && int'(mem_write_col) < COLS)
            shadow[mem_write_row][mem_write_col] = mem_wr_data;
    end

    task automatic cyc(input logic s, input logic c, input logic v, input logic [15:0] d,
                       input logic q, input logic [2:0] r);
        @(negedge clk);
        start = s; clear = c; dp_valid = v; dp_data = d; rd_req = q; rd_row = r;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 3'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset mid-fill, then refill from (0,0)
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 3'd0);
        for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b0, 1'b1, 16'(i), 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b1; dp_valid = 1'b0; start = 1'b0;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dp_ready", 32'(dp_ready), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_row", 32'(mem_write_row), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 3'd0);
        #3;
        chk("refill_wr_en", 32'(mem_wr_en), 32'd1);
        chk("refill_row", 32'(mem_write_row), 32'd0);
        chk("refill_col", 32'(mem_write_col), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 3'd0);
        idle();

        // Full fill with data 1..18
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 3'd0);
        for (int i = 1; i <= N; i++) cyc(1'b0, 1'b0, 1'b1, 16'(i), 1'b0, 3'd0);
        idle();
        #3;
        chk("fill_done_after_18", 32'(fill_done), 32'd1);
        chk("dp_ready_after_18", 32'(dp_ready), 32'd0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                chk("fill_order", 32'(shadow[r][c]), 32'(r * 3 + c + 1));

        // Back-to-back reads 0,5,2 then out-of-range rows 6,7
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 3'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 3'd5);
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 3'd2);
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 3'd6);
        #3;
        chk("read_2_valid", 32'(rd_valid), 32'd1);
        chk("read_2_row", 32'(mem_read_row), 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 3'd7);
        #3;
        chk("err6", 32'(rd_err), 32'd1);
        chk("err6_row_held", 32'(mem_read_row), 32'd2);
        idle();
        #3;
        chk("err7", 32'(rd_err), 32'd1);
        chk("err7_no_valid", 32'(rd_valid), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 3'd0);
        idle();

        // Alternating dp_valid fill
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 3'd0);
        for (int i = 0; i < 2 * N - 1; i++)
            cyc(1'b0, 1'b0, (i % 2) == 0, 16'(i / 2 + 100), 1'b0, 3'd0);
        idle();
        #3;
        chk("alt_fill_done", 32'(fill_done), 32'd1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                chk("alt_order", 32'(shadow[r][c]), 32'(r * 3 + c + 100));
`ifdef FM_WM_STALL_CNT_EN
        chk("stall_17", 32'(stall_cnt), 32'd17);
`endif
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 3'd0);
        idle();

        // clear with dp_valid, start in FILL, rd_req in IDLE
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 1'b1, 16'd2, 1'b0, 3'd0);
        #3;
        chk("start_in_fill_col", 32'(mem_write_col), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 16'd77, 1'b0, 3'd0);
        #3;
        chk("clear_no_write", 32'(mem_wr_en), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 3'd3);
        #3;
        chk("clear_idle", 32'(busy), 32'd0);
        idle();
        #3;
        chk("idle_rd_valid", 32'(rd_valid), 32'd0);
        chk("idle_rd_err", 32'(rd_err), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                cyc($urandom_range(0, 7) == 0, $urandom_range(0, 79) == 0,
                    1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)));
            end
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
